game_state_fsm: RTL and testbench

Top-level game-flow controller for Battle City. It sequences the title screen, active play, inter-round pause and match-win screens, and keeps the per-player round scores. It drives the screen-select lines (initial_screen, green_screen, yellow_screen) consumed directly by the downstream screen multiplexer, plus play-control strobes to the tank and bullet logic.

---
 rtl/game_state_fsm.sv | 101 ++++++++++
 tb/tb_game_state_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/game_state_fsm.sv
// game_state_fsm: Battle City game-flow controller with round scoring and screen selection
module game_state_fsm #(
  parameter int WINS_TO_MATCH      = 3,
  parameter int ROUND_PAUSE_FRAMES = 60,
  parameter int WIN_SCREEN_FRAMES  = 300,
  parameter int SCORE_W            = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               greenHit,
  input  logic               yellowHit,
  output logic               initial_screen,
  output logic               green_screen,
  output logic               yellow_screen,
  output logic               game_active,
  output logic               round_restart,
  output logic [SCORE_W-1:0] green_score,
  output logic [SCORE_W-1:0] yellow_score
);
  localparam int FW = $clog2((ROUND_PAUSE_FRAMES > WIN_SCREEN_FRAMES ?
                              ROUND_PAUSE_FRAMES : WIN_SCREEN_FRAMES) + 1);
  localparam logic [2:0] INIT       = 3'd0;
  localparam logic [2:0] PLAY       = 3'd1;
  localparam logic [2:0] ROUND_END  = 3'd2;
  localparam logic [2:0] GREEN_WIN  = 3'd3;
  localparam logic [2:0] YELLOW_WIN = 3'd4;

  logic [2:0]         r_state;
  logic               r_key_d;
  logic [FW-1:0]      r_cnt;
  logic [2:0]         w_next;
  logic               w_key_edge;
  logic [FW-1:0]      w_cnt_nx;
  logic [SCORE_W-1:0] w_g_nx;
  logic [SCORE_W-1:0] w_y_nx;

  // next-state decode; a draw (both hits) scores nothing and can never end the match
  always_comb begin
    w_key_edge = startKey & ~r_key_d;
    w_cnt_nx   = r_cnt + FW'(startOfFrame);
    w_g_nx     = green_score + SCORE_W'(yellowHit & ~greenHit);
    w_y_nx     = yellow_score + SCORE_W'(greenHit & ~yellowHit);
    w_next     = r_state;
    case (r_state)
      INIT:       w_next = w_key_edge ? PLAY : INIT;
      PLAY:       w_next = !(greenHit | yellowHit) ? PLAY :
                           (w_g_nx == SCORE_W'(WINS_TO_MATCH)) ? GREEN_WIN :
                           (w_y_nx == SCORE_W'(WINS_TO_MATCH)) ? YELLOW_WIN : ROUND_END;
      ROUND_END:  w_next = (w_cnt_nx == FW'(ROUND_PAUSE_FRAMES)) ? PLAY : ROUND_END;
      GREEN_WIN,
      YELLOW_WIN: w_next = (w_key_edge || w_cnt_nx == FW'(WIN_SCREEN_FRAMES)) ? INIT : r_state;
      default:    w_next = INIT;
    endcase
  end

  // state, key history and frame counter; counter restarts on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_key_d <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_key_d <= startKey;
      r_cnt   <= (w_next != r_state || r_state == INIT || r_state == PLAY) ? '0 : w_cnt_nx;
    end
  end

  // registered outputs decoded from the next state so they align with the state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      initial_screen <= 1'b1;
      green_screen   <= 1'b0;
      yellow_screen  <= 1'b0;
      game_active    <= 1'b0;
      round_restart  <= 1'b0;
    end else begin
      initial_screen <= w_next == INIT;
      green_screen   <= w_next == GREEN_WIN;
      yellow_screen  <= w_next == YELLOW_WIN;
      game_active    <= w_next == PLAY;
      round_restart  <= w_next == PLAY && r_state != PLAY;
    end
  end

  // scores clear at match start, change only in PLAY, and are held for the winner screen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      green_score  <= '0;
      yellow_score <= '0;
    end else if (r_state == INIT && w_next == PLAY) begin
      green_score  <= '0;
      yellow_score <= '0;
    end else if (r_state == PLAY) begin
      green_score  <= w_g_nx;
      yellow_score <= w_y_nx;
    end
  end
endmodule

// File: tb/tb_game_state_fsm.sv
// tb_game_state_fsm: directed plus random stimulus checked every cycle against a game-rules model
module tb_game_state_fsm;
  localparam int W  = 3;
  localparam int RP = 60;
  localparam int WS = 300;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic startOfFrame = 1'b0, startKey = 1'b0, greenHit = 1'b0, yellowHit = 1'b0;
  logic initial_screen, green_screen, yellow_screen, game_active, round_restart;
  logic [SW-1:0] green_score, yellow_score;
  int n_checks = 0;
  int n_fail = 0;

  typedef enum {TITLE, PLAYING, PAUSE, GWIN, YWIN} mode_t;
  mode_t m_mode;
  int m_g, m_y, m_frames;
  bit m_prev_key, m_restart;

  always #5 clk = ~clk;

  game_state_fsm #(.WINS_TO_MATCH(W), .ROUND_PAUSE_FRAMES(RP),
                   .WIN_SCREEN_FRAMES(WS), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .startKey(startKey),
    .greenHit(greenHit), .yellowHit(yellowHit), .initial_screen(initial_screen),
    .green_screen(green_screen), .yellow_screen(yellow_screen), .game_active(game_active),
    .round_restart(round_restart), .green_score(green_score), .yellow_score(yellow_score));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("initial_screen", 32'(initial_screen), 32'(m_mode == TITLE));
    chk("green_screen", 32'(green_screen), 32'(m_mode == GWIN));
    chk("yellow_screen", 32'(yellow_screen), 32'(m_mode == YWIN));
    chk("game_active", 32'(game_active), 32'(m_mode == PLAYING));
    chk("round_restart", 32'(round_restart), 32'(m_restart));
    chk("green_score", 32'(green_score), 32'(m_g));
    chk("yellow_score", 32'(yellow_score), 32'(m_y));
  endtask

  task automatic model_reset();
    m_mode = TITLE; m_g = 0; m_y = 0; m_frames = 0; m_prev_key = 1; m_restart = 0;
  endtask

  task automatic model_step(input bit s, input bit k, input bit g, input bit y);
    bit edge_k;
    mode_t nm;
    edge_k = k && !m_prev_key;
    m_prev_key = k;
    nm = m_mode;
    case (m_mode)
      TITLE: if (edge_k) begin nm = PLAYING; m_g = 0; m_y = 0; end
      PLAYING: begin
        if (g && !y) m_y++;
        if (y && !g) m_g++;
        if (g || y) nm = (m_g == W) ? GWIN : (m_y == W) ? YWIN : PAUSE;
      end
      PAUSE: begin
        if (s) m_frames++;
        if (m_frames == RP) nm = PLAYING;
      end
      default: begin
        if (s) m_frames++;
        if (m_frames == WS || edge_k) nm = TITLE;
      end
    endcase
    m_restart = (nm != m_mode) && nm == PLAYING;
    if (nm != m_mode) m_frames = 0;
    m_mode = nm;
  endtask

  task automatic cycle(input bit s, input bit k, input bit g, input bit y);
    @(negedge clk);
    startOfFrame = s; startKey = k; greenHit = g; yellowHit = y;
    @(posedge clk);
    model_step(s, k, g, y);
    #1 check_all();
  endtask

  task automatic do_reset(input bit k);
    @(negedge clk);
    reset = 1; startKey = k; startOfFrame = 0; greenHit = 0; yellowHit = 0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic frames(input int n, input bit k, input bit g);
    for (int i = 0; i < n; i++) begin
      cycle(1, k, g, 0);
      cycle(0, k, 0, 0);
    end
  endtask

  task automatic press();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
  endtask

  initial begin
    bit key;
    do_reset(1);
    repeat (5) cycle(0, 1, 0, 0);
    press();
    chk("start_restart", 32'(round_restart), 32'd1);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    chk("pause_active", 32'(game_active), 32'd0);
    frames(59, 0, 0);
    cycle(1, 0, 0, 0);
    chk("pause_end_restart", 32'(round_restart), 32'd1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    frames(60, 0, 1);
    cycle(0, 0, 0, 1);
    frames(60, 0, 0);
    cycle(0, 0, 0, 1);
    chk("green_win_screen", 32'(green_screen), 32'd1);
    frames(300, 0, 0);
    chk("after_win_title", 32'(initial_screen), 32'd1);
    press();
    chk("match_clear", 32'(green_score), 32'd0);
    for (int r = 0; r < 3; r++) begin
      cycle(0, 1, 1, 0);
      if (r < 2) frames(60, 1, 0);
    end
    chk("yellow_win_screen", 32'(yellow_screen), 32'd1);
    frames(10, 0, 0);
    cycle(0, 1, 0, 0);
    chk("key_exit_title", 32'(initial_screen), 32'd1);
    press();
    cycle(0, 1, 0, 1);
    frames(60, 1, 0);
    cycle(0, 1, 0, 1);
    frames(60, 1, 0);
    cycle(0, 1, 1, 0);
    frames(60, 1, 0);
    chk("score_g_before_reset", 32'(green_score), 32'd2);
    do_reset(0);
    cycle(0, 0, 0, 0);
    key = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2999) == 0) do_reset(key);
      if ($urandom_range(0, 15) == 0) key = ~key;
      cycle(1'($urandom_range(0, 1)), key, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
